// File: rtl/bnn_uart_pkg.sv
// Shared UART definitions for the BNN controller link (RX and TX paths).
package bnn_uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_t;

  localparam int UART_DATA_BITS = 8;

  // 12 MHz system clock at 115200 baud
  localparam int UART_CLKS_PER_BIT = 104;

endpackage

// File: rtl/bnn_byte_fifo.sv
// Small synchronous FIFO with registered occupancy count; head is read straight from storage.
module bnn_byte_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic [$clog2(DEPTH):0]   count_next_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i & ~empty_o;
  // a full FIFO still takes a push when the head leaves in the same cycle
  assign push_ok = push_i & (~full_o | pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
    end
  end

  assign data_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/bnn_uart_rx.sv
// 8N1 UART receiver: synchroniser, mid-bit sampling FSM, byte FIFO and CTS flow control.
//   state | meaning
//   IDLE  | line idle, waiting for rx_s low
//   START | timing to the middle of the start bit
//   DATA  | sampling 8 data bits, LSB first
//   STOP  | timing to the middle of the stop bit
module bnn_uart_rx
  import bnn_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 4,
  parameter int CTS_MARGIN   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_i,
  output logic [7:0] byte_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       cts_o,
  output logic       frame_err_o,
  output logic       overrun_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(UART_DATA_BITS);
  localparam int NW = $clog2(FIFO_DEPTH) + 1;

  rx_state_t                 state_q, state_d;
  logic                      rx_meta_q, rx_s_q;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      push_q, push_d;
  logic                      ferr_q, ferr_d;
  logic                      ovr_q, ovr_d;
  logic                      cts_q, cts_d;
  logic                      expire;
  logic                      pop;
  logic                      fifo_full, fifo_empty;
  logic [NW-1:0]             fifo_count, fifo_count_next;

  assign expire = (cnt_q == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (!rx_s_q) state_d = START;
      START: if (expire) state_d = rx_s_q ? IDLE : DATA;
      DATA:  if (expire && bit_q == BW'(UART_DATA_BITS - 1)) state_d = STOP;
      STOP:  if (expire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    push_d  = 1'b0;
    ferr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = CW'(CLKS_PER_BIT / 2 - 1);
        bit_d = '0;
      end
      START: begin
        if (expire) begin
          cnt_d = CW'(CLKS_PER_BIT - 1);
          bit_d = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      DATA: begin
        if (expire) begin
          shift_d = {rx_s_q, shift_q[UART_DATA_BITS-1:1]};
          cnt_d   = CW'(CLKS_PER_BIT - 1);
          bit_d   = bit_q + BW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      STOP: begin
        if (expire) begin
          push_d = rx_s_q;
          ferr_d = ~rx_s_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: cnt_d = cnt_q;
    endcase
    ovr_d = push_q & fifo_full & ~pop;
    cts_d = (FIFO_DEPTH - int'(fifo_count_next)) > CTS_MARGIN;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      cnt_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      push_q    <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
      cts_q     <= 1'b0;
    end else begin
      rx_meta_q <= rx_i;
      rx_s_q    <= rx_meta_q;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      push_q    <= push_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
      cts_q     <= cts_d;
    end
  end

  // shift_q stays stable in the push cycle: the next frame needs half a bit before any shift
  bnn_byte_fifo #(
    .WIDTH (UART_DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push_q),
    .data_i       (shift_q),
    .pop_i        (pop),
    .data_o       (byte_o),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (fifo_count),
    .count_next_o (fifo_count_next)
  );

  assign valid_o     = (fifo_count != '0);
  assign pop         = valid_o & ready_i;
  assign cts_o       = cts_q;
  assign frame_err_o = ferr_q;
  assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_bnn_uart_rx.sv
// Scoreboard bench for bnn_uart_rx: directed frames, expected bytes queued, monitor pops on handshake.
module tb_bnn_uart_rx;
  import bnn_uart_pkg::*;

  localparam int CPB = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_i = 1'b1;
  logic [7:0] byte_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
  logic       cts_o;
  logic       frame_err_o;
  logic       overrun_o;

  int n_checks = 0;
  int n_fail   = 0;
  int valid_cycles = 0;
  int ferr_cnt = 0;
  int ovr_cnt  = 0;
  logic [7:0] exp_q [$];

  bnn_uart_rx #(
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (4),
    .CTS_MARGIN   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_i        (rx_i),
    .byte_o      (byte_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .cts_o       (cts_o),
    .frame_err_o (frame_err_o),
    .overrun_o   (overrun_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    rx_i = 1'b0;
    repeat (CPB) tick();
    for (int i = 0; i < 8; i++) begin
      rx_i = d[i];
      repeat (CPB) tick();
    end
    rx_i = stop_bit;
    repeat (CPB) tick();
    rx_i = 1'b1;
  endtask

  // monitor: counts pulses and checks every accepted byte against the scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) valid_cycles++;
      if (frame_err_o) ferr_cnt++;
      if (overrun_o) ovr_cnt++;
      if (valid_o && ready_i) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL pop_unexpected: got %0h expected none", byte_o);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (byte_o !== e) begin
            n_fail++;
            $display("FAIL pop_byte: got %0h expected %0h", byte_o, e);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    int lat;
    int c;

    // reset state
    #12;
    chk("rst_byte", 32'(byte_o), 32'h0);
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_cts", 32'(cts_o), 32'h0);
    chk("rst_ferr", 32'(frame_err_o), 32'h0);
    chk("rst_ovr", 32'(overrun_o), 32'h0);
    tick();
    rst = 1'b0;
    chk("cts_before_edge", 32'(cts_o), 32'h0);
    tick();
    chk("cts_after_release", 32'(cts_o), 32'h1);
    repeat (4) tick();

    // single frame 0xA5
    valid_cycles = 0; ferr_cnt = 0; ovr_cnt = 0;
    exp_q.push_back(8'hA5);
    lat = 0;
    fork
      send_byte(8'hA5, 1'b1);
      begin
        while (!valid_o && lat < 200) begin
          tick();
          lat++;
        end
      end
    join
    repeat (10) tick();
    chk("a5_latency_ok", 32'(lat <= 2 + 8 + 152 + 2), 32'h1);
    chk("a5_valid_cycles", 32'(valid_cycles), 32'd1);
    chk("a5_ferr", 32'(ferr_cnt), 32'd0);
    chk("a5_ovr", 32'(ovr_cnt), 32'd0);

    // quarter-bit glitch
    valid_cycles = 0;
    rx_i = 1'b0;
    repeat (CPB / 4) tick();
    rx_i = 1'b1;
    repeat (40) tick();
    chk("glitch_idle", 32'(int'(dut.state_q)), 32'(int'(IDLE)));
    chk("glitch_valid", 32'(valid_cycles), 32'd0);
    chk("glitch_ferr", 32'(ferr_cnt), 32'd0);

    // frame error on 0x3C
    send_byte(8'h3C, 1'b0);
    repeat (40) tick();
    chk("ferr_pulse", 32'(ferr_cnt), 32'd1);
    chk("ferr_valid", 32'(valid_cycles), 32'd0);
    chk("ferr_state", 32'(int'(dut.state_q)), 32'(int'(IDLE)));

    // overflow with ready_i low
    ferr_cnt = 0; ovr_cnt = 0;
    ready_i = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k <= 4) exp_q.push_back(8'(k));
      send_byte(8'(k), 1'b1);
      if (k <= 4) chk($sformatf("cts_after_%0d", k), 32'(cts_o), 32'(((4 - k) > 1) ? 1 : 0));
    end
    repeat (4) tick();
    chk("ovr_pulse", 32'(ovr_cnt), 32'd1);
    chk("ovr_head", 32'(byte_o), 32'h01);
    ready_i = 1'b1;
    repeat (10) tick();
    chk("ovr_drained", 32'(exp_q.size()), 32'd0);
    chk("ovr_cts_back", 32'(cts_o), 32'h1);
    chk("ovr_ferr", 32'(ferr_cnt), 32'd0);

    // full FIFO, push coincident with pop
    ovr_cnt = 0;
    ready_i = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      exp_q.push_back(8'(k * 8'h11));
      send_byte(8'(k * 8'h11), 1'b1);
    end
    exp_q.push_back(8'h55);
    c = 0;
    fork
      send_byte(8'h55, 1'b1);
      begin
        while (!dut.push_q && c < 300) begin
          tick();
          c++;
        end
        ready_i = 1'b1;
        tick();
        ready_i = 1'b0;
      end
    join
    repeat (4) tick();
    chk("coinc_push_seen", 32'(c < 300), 32'h1);
    chk("coinc_ovr", 32'(ovr_cnt), 32'd0);
    chk("coinc_head", 32'(byte_o), 32'h22);
    ready_i = 1'b1;
    repeat (10) tick();
    chk("coinc_drained", 32'(exp_q.size()), 32'd0);

    // reset in the middle of a frame, with a byte waiting in the FIFO
    ready_i = 1'b0;
    send_byte(8'h42, 1'b1);
    repeat (4) tick();
    chk("pre_rst_valid", 32'(valid_o), 32'h1);
    chk("pre_rst_byte", 32'(byte_o), 32'h42);
    rx_i = 1'b0;
    repeat (CPB) tick();
    rx_i = 1'b1; repeat (CPB) tick();
    rx_i = 1'b0; repeat (CPB) tick();
    rx_i = 1'b1; repeat (CPB / 2) tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_byte", 32'(byte_o), 32'h0);
    chk("mid_rst_valid", 32'(valid_o), 32'h0);
    chk("mid_rst_cts", 32'(cts_o), 32'h0);
    chk("mid_rst_ferr", 32'(frame_err_o), 32'h0);
    chk("mid_rst_ovr", 32'(overrun_o), 32'h0);
    rx_i = 1'b0;
    repeat (3) tick();
    rx_i = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    chk("post_rst_cts", 32'(cts_o), 32'h1);
    chk("post_rst_valid", 32'(valid_o), 32'h0);
    ferr_cnt = 0;
    ready_i = 1'b1;
    exp_q.push_back(8'h7E);
    send_byte(8'h7E, 1'b1);
    repeat (20) tick();
    chk("post_rst_drained", 32'(exp_q.size()), 32'd0);
    chk("post_rst_ferr", 32'(ferr_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
